// File: rtl/tqvp_uart_pkg.sv
// Shared definitions for the TinyQV UART transmit peripheral: FSM encoding,
// register addresses and register bit positions.
package tqvp_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_EN    = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

endpackage

// File: rtl/tqvp_uart_tx_fifo_core.sv
// 8N1 serializer: loads a byte when started from IDLE and shifts it out LSB
// first with one start bit and one stop bit.
module uart_tx_core
    import tqvp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 555
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       load_ack
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_baud_done;

    assign w_baud_done = (r_baud == BAUD_LAST);
    // The byte is taken in the same cycle the FIFO pops it.
    assign load_ack    = start && (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign tx          = r_tx;

    // Frame sequencer with baud-rate counter and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= {BW{1'b0}};
                    r_bit  <= 3'd0;
                    if (start) begin
                        r_shift <= din;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud  <= {BW{1'b0}};
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_baud  <= r_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= {BW{1'b0}};
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud  <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= {BW{1'b0}};
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/tqvp_uart_tx_fifo.sv
// TinyQV UART transmit peripheral: register decode and byte FIFO feeding
// the 8N1 serializer on uo_out[0].
module tqvp_uart_tx_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int CLK_HZ = 64_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_enable;
    logic          r_overflow;

    logic w_tx, w_busy, w_pop, w_start;
    logic w_empty, w_full, w_push_req, w_ctrl_wr, w_flush, w_push_ok, w_drop;
    logic w_unused;

    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_full     = (r_count == COUNT_FULL);
    assign w_push_req = data_write && (address == ADDR_DATA);
    assign w_ctrl_wr  = data_write && (address == ADDR_CTRL);
    assign w_flush    = w_ctrl_wr && data_in[CTRL_FLUSH];
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign w_push_ok  = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_flush && !w_push_ok;
    assign w_start    = r_enable && !w_empty;
    assign uo_out     = {7'b0000000, w_tx};
    assign w_unused   = &{1'b0, ui_in};

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .din      (r_mem[r_rd_ptr]),
        .tx       (w_tx),
        .busy     (w_busy),
        .load_ack (w_pop)
    );

    // FIFO storage, pointers and occupancy; flush takes priority over push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (w_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control register and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= data_in[CTRL_EN];
            end
            if (w_ctrl_wr && data_in[CTRL_CLR_OVF]) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Register read mux.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_DATA: begin
                data_out = 8'(r_count);
            end
            ADDR_STATUS: begin
                data_out                = 8'h00;
                data_out[STAT_BUSY]     = w_busy;
                data_out[STAT_EMPTY]    = w_empty;
                data_out[STAT_FULL]     = w_full;
                data_out[STAT_OVF]      = r_overflow;
                data_out[STAT_EN]       = r_enable;
            end
            ADDR_CTRL: begin
                data_out = {7'b0000000, r_enable};
            end
            default: begin
                data_out = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_tqvp_uart_tx_fifo.sv
// Directed bench for tqvp_uart_tx_fifo with 16 clocks per UART bit.
module tb_tqvp_uart_tx_fifo;
    import tqvp_uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vq[$];

    tqvp_uart_tx_fifo #(
        .CLK_HZ (16),
        .BAUD   (1),
        .DEPTH  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
        address = a;
        #1;
        check(nm, data_out, exp);
        @(negedge clk);
        #1;
    endtask

    task automatic vec_add(input logic wr, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            if (vq[i].wr) bus_write(vq[i].addr, vq[i].data);
            else          rd(vq[i].addr, vq[i].exp, $sformatf("%s_vec%0d", tag, i));
        end
        vq.delete();
    endtask

    // Samples the 160 line cycles of one frame; optionally writes CTRL=3 mid-frame.
    task automatic frame_check(input logic [7:0] b, input string nm, input int flush_at);
        logic [9:0] bits;
        int bad_busy;
        bits       = {1'b1, b, 1'b0};
        bad_busy   = 0;
        address    = ADDR_STATUS;
        data_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            int bad_tx;
            bad_tx = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                data_write = 1'b0;
                address    = ADDR_STATUS;
                #1;
                if (uo_out !== {7'b0000000, bits[k]}) bad_tx++;
                if (data_out[STAT_BUSY] !== 1'b1) bad_busy++;
                if (k * 16 + c == flush_at) begin
                    address    = ADDR_CTRL;
                    data_in    = 8'h03;
                    data_write = 1'b1;
                end
            end
            check($sformatf("%s_bit%0d_badcycles", nm, k), bad_tx, 0);
        end
        check($sformatf("%s_busy_badcycles", nm), bad_busy, 0);
    endtask

    task automatic gap_check(input string nm);
        @(negedge clk);
        address = ADDR_STATUS;
        #1;
        check({nm, "_gap_tx"}, uo_out, 8'h01);
        check({nm, "_gap_busy"}, data_out[STAT_BUSY], 1'b0);
    endtask

    task automatic stay_idle(input int n, input string nm);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (uo_out !== 8'h01) bad++;
        end
        check({nm, "_idle_badcycles"}, bad, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ui_in      = 8'h5A;
        address    = 4'h0;
        data_in    = 8'h00;
        data_write = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t1_uo_in_reset", uo_out, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_uo_after_reset", uo_out, 8'h01);

        // 1: reset register values
        vec_add(1'b0, ADDR_STATUS, 8'h00, 8'h12);
        vec_add(1'b0, ADDR_DATA,   8'h00, 8'h00);
        vec_add(1'b0, 4'hF,        8'h00, 8'h00);
        vec_add(1'b0, ADDR_CTRL,   8'h00, 8'h01);
        run_vecs("t1");

        // 2: single frame and push-to-start latency
        bus_write(ADDR_DATA, 8'h55);
        check("t2_latency_tx_still_high", uo_out, 8'h01);
        frame_check(8'h55, "t2", -1);
        gap_check("t2");

        // 3: fill while disabled, overflow on the 17th push, then drain in order
        vec_add(1'b1, ADDR_CTRL, 8'h00, 8'h00);
        for (int k = 0; k < 17; k++) vec_add(1'b1, ADDR_DATA, 8'(k), 8'h00);
        vec_add(1'b0, ADDR_DATA,   8'h00, 8'h10);
        vec_add(1'b0, ADDR_STATUS, 8'h00, 8'h0C);
        vec_add(1'b0, ADDR_CTRL,   8'h00, 8'h00);
        run_vecs("t3");
        bus_write(ADDR_CTRL, 8'h01);
        for (int k = 0; k < 16; k++) begin
            frame_check(8'(k), $sformatf("t3_f%0d", k), -1);
            gap_check($sformatf("t3_f%0d", k));
        end
        stay_idle(200, "t3");
        rd(ADDR_DATA,   8'h00, "t3_count_end");
        rd(ADDR_STATUS, 8'h1A, "t3_status_end");

        // 4: flush during the first of three queued frames
        bus_write(ADDR_CTRL, 8'h04);
        bus_write(ADDR_DATA, 8'hA5);
        bus_write(ADDR_DATA, 8'h3C);
        bus_write(ADDR_DATA, 8'h0F);
        rd(ADDR_DATA, 8'h03, "t4_count_queued");
        bus_write(ADDR_CTRL, 8'h01);
        frame_check(8'hA5, "t4", 50);
        gap_check("t4");
        rd(ADDR_DATA,   8'h00, "t4_count_flushed");
        rd(ADDR_STATUS, 8'h12, "t4_status");
        stay_idle(300, "t4");

        // 5: asynchronous reset in the middle of the data bits
        bus_write(ADDR_DATA, 8'h55);
        repeat (40) @(negedge clk);
        #1;
        check("t5_tx_low_before_reset", uo_out, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_tx_async_high", uo_out, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rd(ADDR_STATUS, 8'h12, "t5_status");
        rd(ADDR_DATA,   8'h00, "t5_count");
        stay_idle(200, "t5");

        // 6: clear overflow while re-enabling
        vec_add(1'b1, ADDR_CTRL, 8'h00, 8'h00);
        for (int k = 0; k < 17; k++) vec_add(1'b1, ADDR_DATA, 8'hA0 + 8'(k), 8'h00);
        vec_add(1'b0, ADDR_STATUS, 8'h00, 8'h0C);
        vec_add(1'b1, ADDR_CTRL,   8'h05, 8'h00);
        vec_add(1'b0, ADDR_STATUS, 8'h00, 8'h14);
        vec_add(1'b0, ADDR_CTRL,   8'h00, 8'h01);
        run_vecs("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
